lector_conteos: RTL and testbench

LECTOR_CONTEOS -- requirements
Module: lector_conteos

---
 rtl/lector_conteos.sv | 149 ++++++++++++++
 tb/tb_lector_conteos.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lector_conteos.sv
// lector_conteos: sweeps the four per-FIFO word counters of an upstream
// counter bank, strobing each captured count and accumulating their total.
//
// Handshake with the counter bank: the bank raises valid while its counts
// are readable. The sweep begins only once valid is seen. req is then high
// for one cycle with idx naming the FIFO. The count is taken from data in
// the following cycle, and valid must still be high at that point. If valid
// has dropped, the data is discarded and the sweep aborts with error set.
module lector_conteos #(
    parameter int DATA_BITS = 5,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   valid,
    input  logic [DATA_BITS-1:0]   data,
    output logic                   req,
    output logic [1:0]             idx,
    output logic [DATA_BITS-1:0]   cnt_out,
    output logic [1:0]             cnt_idx,
    output logic                   cnt_valid,
    output logic [DATA_BITS+1:0]   total,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             dbg_state
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_VALID = 3'd1,
        S_REQ        = 3'd2,
        S_CAPTURE    = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             index_q, index_d;
    logic [TW-1:0]          tcount_q, tcount_d;
    logic [DATA_BITS-1:0]   cnt_out_q, cnt_out_d;
    logic [1:0]             cnt_idx_q, cnt_idx_d;
    logic                   cnt_valid_q, cnt_valid_d;
    logic [DATA_BITS+1:0]   total_q, total_d;
    logic                   error_q, error_d;

    // Next-state and datapath updates for the sweep sequencer
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        tcount_d    = tcount_q;
        cnt_out_d   = cnt_out_q;
        cnt_idx_d   = cnt_idx_q;
        cnt_valid_d = 1'b0;
        total_d     = total_q;
        error_d     = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WAIT_VALID;
                    total_d  = '0;
                    error_d  = 1'b0;
                    tcount_d = '0;
                    index_d  = 2'd0;
                end
            end
            S_WAIT_VALID: begin
                if (valid) begin
                    state_d = S_REQ;
                end else if (tcount_q == TMAX) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                end else begin
                    tcount_d = tcount_q + 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (valid) begin
                    cnt_out_d   = data;
                    cnt_idx_d   = index_q;
                    cnt_valid_d = 1'b1;
                    // Four counts of DATA_BITS each fit in DATA_BITS+2 bits
                    total_d     = total_q + (DATA_BITS+2)'(data);
                    if (index_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 2'd1;
                        state_d = S_REQ;
                    end
                end else begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            index_q     <= 2'd0;
            tcount_q    <= '0;
            cnt_out_q   <= '0;
            cnt_idx_q   <= 2'd0;
            cnt_valid_q <= 1'b0;
            total_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            tcount_q    <= tcount_d;
            cnt_out_q   <= cnt_out_d;
            cnt_idx_q   <= cnt_idx_d;
            cnt_valid_q <= cnt_valid_d;
            total_q     <= total_d;
            error_q     <= error_d;
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        req  = (state_q == S_REQ);
        busy = (state_q == S_WAIT_VALID) || (state_q == S_REQ) ||
               (state_q == S_CAPTURE);
        done = (state_q == S_DONE);
    end

    assign idx       = index_q;
    assign cnt_out   = cnt_out_q;
    assign cnt_idx   = cnt_idx_q;
    assign cnt_valid = cnt_valid_q;
    assign total     = total_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lector_conteos.sv
// Directed bench for lector_conteos: normal sweeps, timeout, valid drop,
// ignored re-start, mid-sweep reset and maximum counts.
module tb_lector_conteos;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       valid;
    logic [4:0] data;
    logic       req;
    logic [1:0] idx;
    logic [4:0] cnt_out;
    logic [1:0] cnt_idx;
    logic       cnt_valid;
    logic [6:0] total;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    logic [4:0] bank [4];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    lector_conteos #(.DATA_BITS(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .data(data),
        .req(req), .idx(idx), .cnt_out(cnt_out), .cnt_idx(cnt_idx),
        .cnt_valid(cnt_valid), .total(total), .busy(busy), .done(done),
        .error(error), .dbg_state(dbg_state)
    );

    // clock / counter bank model
    always #5 clk = ~clk;
    assign data = bank[idx];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // mode 0: clean sweep, 1: valid never high, 2: valid drops in CAPTURE idx1,
    // 3: start re-pulsed mid-sweep
    task automatic run_sweep(input int mode);
        logic [31:0] exp_q[$];
        logic [31:0] req_q[$];
        logic [31:0] rec;
        int exp_done, exp_err, exp_total, done_cnt;
        exp_q.delete();
        req_q.delete();
        done_cnt = 0;
        if (mode == 1) begin
            exp_done = 17; exp_err = 1; exp_total = 0;
        end else if (mode == 2) begin
            exp_q.push_back((32'd4 << 16) | (32'd0 << 8) | 32'(bank[0]));
            req_q.push_back((32'd2 << 8) | 32'd0);
            req_q.push_back((32'd4 << 8) | 32'd1);
            exp_done = 6; exp_err = 1; exp_total = int'(bank[0]);
        end else begin
            exp_total = 0;
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back((32'(4 + 2*k) << 16) | (32'(k) << 8) | 32'(bank[k]));
                req_q.push_back((32'(2 + 2*k) << 8) | 32'(k));
                exp_total += int'(bank[k]);
            end
            exp_done = 10; exp_err = 0;
        end

        @(posedge clk); #1;
        start = 1'b1;
        valid = (mode != 1);
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_c1", 32'(busy), 1);
                check("err_clr", 32'(error), 0);
            end
            if (req) begin
                rec = (32'(cyc) << 8) | 32'(idx);
                if (req_q.size() == 0) check("req_extra", rec, 32'hFFFF_FFFF);
                else check("req", rec, req_q.pop_front());
            end
            if (cnt_valid) begin
                rec = (32'(cyc) << 16) | (32'(cnt_idx) << 8) | 32'(cnt_out);
                if (exp_q.size() == 0) check("cv_extra", rec, 32'hFFFF_FFFF);
                else check("cnt_valid", rec, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("done_cyc", 32'(cyc), 32'(exp_done));
                check("done_err", 32'(error), 32'(exp_err));
                check("done_total", 32'(total), 32'(exp_total));
                check("done_busy", 32'(busy), 0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 3 && (cyc + 1 == 4 || cyc + 1 == 7)) start = 1'b1;
            if (mode == 2) valid = (cyc + 1 != 5);
        end
        valid = 1'b1;
        check("done_cnt", 32'(done_cnt), 1);
        check("cv_missing", 32'(exp_q.size()), 0);
        check("req_missing", 32'(req_q.size()), 0);
    endtask

    initial begin
        int seen;
        rst   = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        bank[0] = 5'd0; bank[1] = 5'd0; bank[2] = 5'd0; bank[3] = 5'd0;

        // reset state
        @(negedge clk);
        check("rst_req", 32'(req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_total", 32'(total), 0);
        check("rst_err", 32'(error), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // counts 3,7,0,31
        bank[0] = 5'd3; bank[1] = 5'd7; bank[2] = 5'd0; bank[3] = 5'd31;
        run_sweep(0);
        repeat (3) @(negedge clk);
        check("hold_total", 32'(total), 41);
        check("hold_cnt_out", 32'(cnt_out), 31);

        // timeout with valid low
        run_sweep(1);
        check("err_sticky", 32'(error), 1);

        // valid drops during CAPTURE of idx1
        bank[0] = 5'd9; bank[1] = 5'd12; bank[2] = 5'd4; bank[3] = 5'd1;
        run_sweep(2);

        // re-pulsed start, all counts 31
        bank[0] = 5'd31; bank[1] = 5'd31; bank[2] = 5'd31; bank[3] = 5'd31;
        run_sweep(3);

        // reset during REQ idx2
        bank[0] = 5'd3; bank[1] = 5'd7; bank[2] = 5'd0; bank[3] = 5'd31;
        @(posedge clk); #1;
        start = 1'b1;
        valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_req", 32'(req), 1);
        check("pre_rst_idx", 32'(idx), 2);
        rst = 1'b0;
        #1;
        check("arst_req", 32'(req), 0);
        check("arst_idx", 32'(idx), 0);
        check("arst_cnt_out", 32'(cnt_out), 0);
        check("arst_cnt_idx", 32'(cnt_idx), 0);
        check("arst_cnt_valid", 32'(cnt_valid), 0);
        check("arst_total", 32'(total), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_err", 32'(error), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || cnt_valid || busy) seen++;
        end
        check("post_rst_quiet", 32'(seen), 0);

        // clean sweep after reset
        run_sweep(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
